// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - signal bundle between the fetch/data masters, the arbiter and the shared memory port
//
// Purpose: groups every handshake and bus signal of mem_arbiter.
//   slave modport  : view taken by the arbiter (requests in, acks/bus out)
//   master modport : view taken by the environment (CPU side and memory slave)
// Signals:
//   if_ce_i, if_addr_i[31:0]                      fetch request
//   if_data_o[31:0], if_ack_o                     fetch completion
//   d_ce_i, d_we_i, d_sel_i[3:0], d_addr_i[31:0],
//   d_wdata_i[31:0]                               data request
//   d_rdata_o[31:0], d_ack_o                      data completion
//   bus_req_o, bus_we_o, bus_sel_o[3:0],
//   bus_addr_o[31:0], bus_wdata_o[31:0]           shared memory port (registered)
//   bus_rdata_i[31:0], bus_ack_i                  memory slave response
//   stallreq_o                                    pipeline stall request
//   err_o                                         timeout abort pulse
interface mem_arbiter_if;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;

    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    logic        stallreq_o;
    logic        err_o;

    modport slave (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  d_ce_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_ack_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i,
        output stallreq_o, err_o
    );

    modport master (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output d_ce_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_ack_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i,
        input  stallreq_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) arbiter onto a single shared memory port
//
// Purpose: grants one access at a time to either the instruction-fetch or
// the data master, alternating on contention, forwards the request onto the
// registered shared bus, returns the slave response as a one-cycle ack and
// aborts an access that waits TIMEOUT cycles without a slave ack.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   port  mem_arbiter_if.slave - fetch, data, shared bus, stall and error signals
// Parameter:
//   TIMEOUT  cycles a granted access may wait for bus_ack_i before abort
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  port
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The counter holds the number of ack-less cycles already spent; the
    // cycle in which it equals TIMEOUT-1 is the last one allowed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;       // 1: last grant went to D, 0: to I
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        err_q, err_d;

    logic        d_elig, i_elig, grant_d, grant_i;

    // A master whose ack is showing this cycle has just been served; it is
    // not eligible again until the pulse has gone, so the other master can
    // be granted in the same cycle.
    assign d_elig  = port.d_ce_i & ~d_ack_q;
    assign i_elig  = port.if_ce_i & ~if_ack_q;
    assign grant_d = d_elig & (~i_elig | ~last_d_q);
    assign grant_i = i_elig & ~grant_d;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = GNT_D;
                    last_d_d    = 1'b1;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port.d_we_i;
                    bus_sel_d   = port.d_sel_i;
                    bus_addr_d  = port.d_addr_i;
                    bus_wdata_d = port.d_wdata_i;
                end else if (grant_i) begin
                    state_d     = GNT_I;
                    last_d_d    = 1'b0;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = port.if_addr_i;
                    bus_wdata_d = 32'h0;
                end
            end

            GNT_D, GNT_I: begin
                // Slave ack takes priority over an expiring counter.
                if (port.bus_ack_i) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == GNT_D) begin
                        d_ack_d = 1'b1;
                        if (!bus_we_q) d_rdata_d = port.bus_rdata_i;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = port.bus_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == GNT_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = 32'h0;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_data_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign port.bus_req_o   = bus_req_q;
    assign port.bus_we_o    = bus_we_q;
    assign port.bus_sel_o   = bus_sel_q;
    assign port.bus_addr_o  = bus_addr_q;
    assign port.bus_wdata_o = bus_wdata_q;
    assign port.if_ack_o    = if_ack_q;
    assign port.d_ack_o     = d_ack_q;
    assign port.if_data_o   = if_data_q;
    assign port.d_rdata_o   = d_rdata_q;
    assign port.err_o       = err_q;
    assign port.stallreq_o  = (port.if_ce_i & ~if_ack_q) | (port.d_ce_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_if ifc();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (ifc.slave)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.if_ce_i     = 1'b0;
        ifc.if_addr_i   = 32'h0;
        ifc.d_ce_i      = 1'b0;
        ifc.d_we_i      = 1'b0;
        ifc.d_sel_i     = 4'h0;
        ifc.d_addr_i    = 32'h0;
        ifc.d_wdata_i   = 32'h0;
        ifc.bus_rdata_i = 32'h0;
        ifc.bus_ack_i   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_bus_ctl: got %b required 000000", {ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o});
        end
        n_checks++;
        if ({ifc.bus_addr_o, ifc.bus_wdata_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus_data: got %h required 0", {ifc.bus_addr_o, ifc.bus_wdata_o});
        end
        n_checks++;
        if ({ifc.if_ack_o, ifc.d_ack_o, ifc.err_o, ifc.stallreq_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b required 0000", {ifc.if_ack_o, ifc.d_ack_o, ifc.err_o, ifc.stallreq_o});
        end
        n_checks++;
        if ({ifc.if_data_o, ifc.d_rdata_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 0", {ifc.if_data_o, ifc.d_rdata_o});
        end
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_single_fetch();
        ifc.if_ce_i   = 1'b1;
        ifc.if_addr_i = 32'h0000_0010;
        #1;
        n_checks++;
        if (ifc.stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_stall_req: got %b required 1", ifc.stallreq_o);
        end
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
            n_fail++;
            $display("FAIL fetch_bus: got req=%b we=%b sel=%h addr=%h required 1 0 f 00000010",
                     ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o);
        end
        n_checks++;
        if ({ifc.if_ack_o, ifc.stallreq_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL fetch_wait: got ack=%b stall=%b required 0 1", ifc.if_ack_o, ifc.stallreq_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'h3401_1100;
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.if_data_o, ifc.bus_req_o, ifc.stallreq_o} !== {1'b1, 32'h3401_1100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_ack: got ack=%b data=%h req=%b stall=%b required 1 34011100 0 0",
                     ifc.if_ack_o, ifc.if_data_o, ifc.bus_req_o, ifc.stallreq_o);
        end
        idle_inputs();
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_pulse: got ack=%b err=%b required 0 0", ifc.if_ack_o, ifc.err_o);
        end
    endtask

    task automatic test_contention();
        rst = 1'b0;
        step();
        rst = 1'b1;
        ifc.if_ce_i  = 1'b1;
        ifc.if_addr_i = 32'h200;
        ifc.d_ce_i   = 1'b1;
        ifc.d_we_i   = 1'b0;
        ifc.d_sel_i  = 4'hF;
        ifc.d_addr_i = 32'h300;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL cont_first_d: got req=%b addr=%h required 1 00000300", ifc.bus_req_o, ifc.bus_addr_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hAAAA_0001;
        step();
        n_checks++;
        if ({ifc.d_ack_o, ifc.d_rdata_o, ifc.if_ack_o} !== {1'b1, 32'hAAAA_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL cont_d_ack: got dack=%b rdata=%h iack=%b required 1 aaaa0001 0",
                     ifc.d_ack_o, ifc.d_rdata_o, ifc.if_ack_o);
        end
        ifc.d_ce_i    = 1'b0;
        ifc.bus_ack_i = 1'b0;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o, ifc.bus_sel_o} !== {1'b1, 32'h200, 4'hF}) begin
            n_fail++;
            $display("FAIL cont_i_b2b: got req=%b addr=%h sel=%h required 1 00000200 f",
                     ifc.bus_req_o, ifc.bus_addr_o, ifc.bus_sel_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hBBBB_0002;
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.if_data_o} !== {1'b1, 32'hBBBB_0002}) begin
            n_fail++;
            $display("FAIL cont_i_ack: got ack=%b data=%h required 1 bbbb0002", ifc.if_ack_o, ifc.if_data_o);
        end
        // D alone, so that the next contention goes to I.
        ifc.if_ce_i   = 1'b0;
        ifc.bus_ack_i = 1'b0;
        ifc.d_ce_i    = 1'b1;
        ifc.d_addr_i  = 32'h304;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o} !== {1'b1, 32'h304}) begin
            n_fail++;
            $display("FAIL cont_d_alone: got req=%b addr=%h required 1 00000304", ifc.bus_req_o, ifc.bus_addr_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hCCCC_0003;
        step();
        ifc.d_ce_i    = 1'b0;
        ifc.bus_ack_i = 1'b0;
        step();
        ifc.if_ce_i   = 1'b1;
        ifc.if_addr_i = 32'h208;
        ifc.d_ce_i    = 1'b1;
        ifc.d_addr_i  = 32'h308;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o} !== {1'b1, 32'h208}) begin
            n_fail++;
            $display("FAIL cont_alternate_i: got req=%b addr=%h required 1 00000208", ifc.bus_req_o, ifc.bus_addr_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hDDDD_0004;
        step();
        ifc.if_ce_i   = 1'b0;
        ifc.bus_ack_i = 1'b0;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o} !== {1'b1, 32'h308}) begin
            n_fail++;
            $display("FAIL cont_then_d: got req=%b addr=%h required 1 00000308", ifc.bus_req_o, ifc.bus_addr_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hEEEE_0005;
        step();
        n_checks++;
        if ({ifc.d_ack_o, ifc.d_rdata_o} !== {1'b1, 32'hEEEE_0005}) begin
            n_fail++;
            $display("FAIL cont_d2_ack: got ack=%b rdata=%h required 1 eeee0005", ifc.d_ack_o, ifc.d_rdata_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_store();
        ifc.d_ce_i      = 1'b1;
        ifc.d_we_i      = 1'b1;
        ifc.d_sel_i     = 4'b0011;
        ifc.d_addr_i    = 32'h100;
        ifc.d_wdata_i   = 32'hDEAD_BEEF;
        ifc.bus_rdata_i = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.bus_wdata_o, ifc.d_ack_o}
                !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL store_bus_cycle%0d: got req=%b we=%b sel=%h addr=%h wdata=%h ack=%b required 1 1 3 00000100 deadbeef 0",
                         i, ifc.bus_req_o, ifc.bus_we_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.bus_wdata_o, ifc.d_ack_o);
            end
            if (i == 3) ifc.bus_ack_i = 1'b1;
        end
        step();
        n_checks++;
        if ({ifc.d_ack_o, ifc.d_rdata_o, ifc.err_o, ifc.bus_req_o} !== {1'b1, 32'hEEEE_0005, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_ack: got ack=%b rdata=%h err=%b req=%b required 1 eeee0005 0 0",
                     ifc.d_ack_o, ifc.d_rdata_o, ifc.err_o, ifc.bus_req_o);
        end
        idle_inputs();
        step();
        n_checks++;
        if (ifc.d_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse: got ack=%b required 0", ifc.d_ack_o);
        end
    endtask

    task automatic test_timeout();
        ifc.d_ce_i   = 1'b1;
        ifc.d_we_i   = 1'b0;
        ifc.d_sel_i  = 4'hF;
        ifc.d_addr_i = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({ifc.bus_req_o, ifc.d_ack_o, ifc.err_o} !== 3'b100) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got req=%b ack=%b err=%b required 1 0 0",
                         i, ifc.bus_req_o, ifc.d_ack_o, ifc.err_o);
            end
        end
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.d_ack_o, ifc.d_rdata_o, ifc.err_o} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_abort: got req=%b ack=%b rdata=%h err=%b required 0 1 00000000 1",
                     ifc.bus_req_o, ifc.d_ack_o, ifc.d_rdata_o, ifc.err_o);
        end
        idle_inputs();
        step();
        n_checks++;
        if ({ifc.d_ack_o, ifc.err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_pulse: got ack=%b err=%b required 0 0", ifc.d_ack_o, ifc.err_o);
        end
    endtask

    task automatic test_tie();
        // An ack while nothing is granted must be ignored.
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.d_ack_o, ifc.bus_req_o, ifc.err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got %b required 0000",
                     {ifc.if_ack_o, ifc.d_ack_o, ifc.bus_req_o, ifc.err_o});
        end
        ifc.bus_ack_i = 1'b0;
        ifc.if_ce_i   = 1'b1;
        ifc.if_addr_i = 32'h600;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({ifc.bus_req_o, ifc.if_ack_o} !== 2'b10) begin
                n_fail++;
                $display("FAIL tie_wait%0d: got req=%b ack=%b required 1 0", i, ifc.bus_req_o, ifc.if_ack_o);
            end
            if (i == 3) begin
                ifc.bus_ack_i   = 1'b1;
                ifc.bus_rdata_i = 32'h5555_AAAA;
            end
        end
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.if_data_o, ifc.err_o, ifc.bus_req_o} !== {1'b1, 32'h5555_AAAA, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_ack_wins: got ack=%b data=%h err=%b req=%b required 1 5555aaaa 0 0",
                     ifc.if_ack_o, ifc.if_data_o, ifc.err_o, ifc.bus_req_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        ifc.if_ce_i   = 1'b1;
        ifc.if_addr_i = 32'h500;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o} !== {1'b1, 32'h500}) begin
            n_fail++;
            $display("FAIL rstmid_granted: got req=%b addr=%h required 1 00000500", ifc.bus_req_o, ifc.bus_addr_o);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.if_ack_o, ifc.if_data_o, ifc.err_o} !== 71'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b sel=%h addr=%h ack=%b data=%h err=%b required all 0",
                     ifc.bus_req_o, ifc.bus_sel_o, ifc.bus_addr_o, ifc.if_ack_o, ifc.if_data_o, ifc.err_o);
        end
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({ifc.bus_req_o, ifc.bus_addr_o, ifc.if_ack_o, ifc.err_o} !== {1'b1, 32'h500, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got req=%b addr=%h ack=%b err=%b required 1 00000500 0 0",
                     ifc.bus_req_o, ifc.bus_addr_o, ifc.if_ack_o, ifc.err_o);
        end
        ifc.bus_ack_i   = 1'b1;
        ifc.bus_rdata_i = 32'h7777_0007;
        step();
        n_checks++;
        if ({ifc.if_ack_o, ifc.if_data_o} !== {1'b1, 32'h7777_0007}) begin
            n_fail++;
            $display("FAIL rstmid_ack: got ack=%b data=%h required 1 77770007", ifc.if_ack_o, ifc.if_data_o);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
